// File: rtl/sprite_pkg.sv
// sprite_pkg: shared defaults, descriptor layout, register map and FSM encoding
// for sprite_attr_table.
package sprite_pkg;
    localparam int NUM_SPRITES_DEF = 20;
    localparam int VBLANK_LINE_DEF = 480;
    localparam int ID_W   = 5;
    localparam int X_W    = 9;
    localparam int Y_W    = 10;
    localparam int DESC_W = ID_W + X_W + Y_W;
    localparam logic [4:0] ADDR_IRQ_ACK = 5'd30;
    localparam logic [4:0] ADDR_CTRL    = 5'd31;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
    } sprite_desc_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COPY} sat_state_e;
endpackage

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: CPU-written shadow descriptor table copied into the display-side
// active table one slot per cycle at vblank start. Define SAT_READBACK_EN for shadow readback.
module sprite_attr_table
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int VBLANK_LINE = VBLANK_LINE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [9:0]  VGA_HCOUNT,
    input  logic [9:0]  VGA_VCOUNT,
    input  logic [4:0]  rd_slot,
    output logic [23:0] rd_desc,
    output logic        frame_irq
);
    localparam logic [4:0] NSP  = 5'(NUM_SPRITES);
    localparam logic [4:0] LAST = 5'(NUM_SPRITES - 1);

    sat_state_e   state_q, state_d;
    sprite_desc_t shadow_q [NUM_SPRITES];
    sprite_desc_t active_q [NUM_SPRITES];
    logic [4:0]   idx_q, idx_d;
    logic         pending_q, pending_d, rearm_q, rearm_d, irq_q, irq_d, vb_hit_q;
    logic [31:0]  readdata_q, rdata_d, status;
    logic [23:0]  rd_desc_q;
    logic         vb_hit, vblank_start, wr, shadow_addr, commit_wr, ack_wr, shadow_we;
    logic         copy_en, copy_done;
    logic         unused_hi;

    assign vb_hit       = VGA_VCOUNT == 10'(VBLANK_LINE) && VGA_HCOUNT == 10'd0;
    assign vblank_start = vb_hit && !vb_hit_q;
    assign wr           = chipselect && write;
    assign shadow_addr  = address < NSP;
    assign commit_wr    = wr && address == ADDR_CTRL && writedata[0];
    assign ack_wr       = wr && address == ADDR_IRQ_ACK;
    assign waitrequest  = state_q == ST_COPY && wr && shadow_addr;
    assign shadow_we    = wr && shadow_addr && !waitrequest;
    assign status       = {30'b0, irq_q, pending_q};
    assign unused_hi    = ^writedata[31:DESC_W];

`ifdef SAT_READBACK_EN
    assign rdata_d = address == ADDR_CTRL ? status : shadow_addr ? {8'b0, shadow_q[address]} : 32'd0;
`else
    assign rdata_d = address == ADDR_CTRL ? status : 32'd0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;

    always_comb
        state_d = state_q == ST_IDLE  ? (pending_q ? ST_ARMED : ST_IDLE) :
                  state_q == ST_ARMED ? (vblank_start ? ST_COPY : ST_ARMED) :
                  copy_done           ? ST_IDLE : ST_COPY;

    // A commit landing mid-copy is parked in rearm_q so the exit clear cannot swallow it.
    always_comb begin
        copy_en   = state_q == ST_COPY;
        copy_done = copy_en && idx_q == LAST;
        idx_d     = copy_en && !copy_done ? idx_q + 5'd1 : 5'd0;
        pending_d = copy_done ? rearm_q || commit_wr : pending_q || commit_wr;
        rearm_d   = copy_en && !copy_done && (rearm_q || commit_wr);
        irq_d     = copy_done || (irq_q && !ack_wr);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            idx_q      <= '0;
            pending_q  <= 1'b0;
            rearm_q    <= 1'b0;
            irq_q      <= 1'b0;
            vb_hit_q   <= 1'b0;
            readdata_q <= '0;
            rd_desc_q  <= '0;
        end else begin
            if (shadow_we) shadow_q[address] <= sprite_desc_t'(writedata[DESC_W-1:0]);
            if (copy_en) active_q[idx_q] <= shadow_q[idx_q];
            if (chipselect && read) readdata_q <= rdata_d;
            rd_desc_q <= rd_slot < NSP ? active_q[rd_slot] : '0;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            rearm_q   <= rearm_d;
            irq_q     <= irq_d;
            vb_hit_q  <= vb_hit;
        end

    assign readdata  = readdata_q;
    assign rd_desc   = rd_desc_q;
    assign frame_irq = irq_q;
endmodule

// File: tb/tb_sprite_attr_table.sv
// tb_sprite_attr_table: randomized scenario bench for sprite_attr_table against a
// table-level model (shadow/active arrays, pending and irq flags).
module tb_sprite_attr_table;
    localparam int N = 20;

    logic        clk = 0, reset_n = 0, chipselect = 0, write = 0, read = 0;
    logic [4:0]  address = 0, rd_slot = 0;
    logic [31:0] writedata = 0, readdata;
    logic        waitrequest, frame_irq;
    logic [9:0]  vga_hcount = 10'd5, vga_vcount = 10'd100;
    logic [23:0] rd_desc;

    logic [23:0] shadow_m [N];
    logic [23:0] active_m [N];
    logic        pending_m = 0, irq_m = 0;
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;

    sprite_attr_table dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .VGA_HCOUNT(vga_hcount), .VGA_VCOUNT(vga_vcount), .rd_slot(rd_slot), .rd_desc(rd_desc),
        .frame_irq(frame_irq)
    );

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin shadow_m[i] = '0; active_m[i] = '0; end
        pending_m = 0; irq_m = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, output int stalls);
        chipselect = 1; write = 1; address = a; writedata = d; stalls = 0;
        #1;
        while (waitrequest && stalls < 200) begin @(negedge clk); #1; stalls++; end
        @(negedge clk);
        chipselect = 0; write = 0;
        if (int'(a) < N) shadow_m[a] = d[23:0];
        if (a == 5'd30) irq_m = 0;
        if (a == 5'd31 && d[0]) pending_m = 1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        chipselect = 1; read = 1; address = a;
        @(negedge clk);
        chipselect = 0; read = 0; d = readdata;
    endtask

    task automatic get_desc(input logic [4:0] s, output logic [23:0] d);
        rd_slot = s;
        @(negedge clk);
        d = rd_desc;
    endtask

    // A vblank with a commit pending snapshots the whole shadow table into active.
    task automatic vblank();
        vga_vcount = 10'd480; vga_hcount = 10'd0;
        @(negedge clk);
        vga_hcount = 10'd5; vga_vcount = 10'd100;
        if (pending_m) begin
            for (int i = 0; i < N; i++) active_m[i] = shadow_m[i];
            pending_m = 0;
        end
    endtask

    task automatic wait_irq(output int c);
        c = 0;
        while (frame_irq !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        if (c < 200) irq_m = 1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset_n = 0;
        idle(3);
        vectors++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        vectors++; if (rd_desc !== 24'd0) begin errors++; $display("FAIL reset_rd_desc got=%h exp=0", rd_desc); end
        vectors++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", frame_irq); end
        vectors++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", waitrequest); end
        reset_n = 1;
        model_clear();
        idle(1);
        bus_read(5'd31, r);
        vectors++; if (r !== 32'd0) begin errors++; $display("FAIL reset_status got=%h exp=0", r); end
    endtask

    task automatic test_basic();
        int st, c; logic [31:0] r; logic [23:0] d;
        bus_write(5'd3, 32'h000A1234, st);
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        wait_irq(c);
        vectors++; if (c != N) begin errors++; $display("FAIL basic_copy_len got=%0d exp=%0d", c, N); end
        get_desc(5'd3, d);
        vectors++; if (d !== 24'h0A1234) begin errors++; $display("FAIL basic_desc got=%h exp=0a1234", d); end
        vectors++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b exp=1", frame_irq); end
        bus_read(5'd31, r);
        vectors++; if (r !== 32'd2) begin errors++; $display("FAIL basic_status got=%h exp=2", r); end
    endtask

    task automatic test_no_commit();
        int st; logic [31:0] r, e; logic [23:0] d;
        bus_write(5'd30, 32'd0, st);
        bus_write(5'd7, $urandom | 32'h0080_0000, st);
        vblank();
        idle(N + 5);
        get_desc(5'd7, d);
        vectors++; if (d !== active_m[7]) begin errors++; $display("FAIL nocommit_desc got=%h exp=%h", d, active_m[7]); end
        vectors++; if (frame_irq !== irq_m) begin errors++; $display("FAIL nocommit_irq got=%b exp=%b", frame_irq, irq_m); end
        bus_read(5'd31, r);
        vectors++; if (r !== {30'b0, irq_m, pending_m}) begin errors++; $display("FAIL nocommit_status got=%h exp=%h", r, {30'b0, irq_m, pending_m}); end
        bus_read(5'd7, r);
`ifdef SAT_READBACK_EN
        e = {8'b0, shadow_m[7]};
`else
        e = 32'd0;
`endif
        vectors++; if (r !== e) begin errors++; $display("FAIL nocommit_readback got=%h exp=%h", r, e); end
    endtask

    task automatic test_random(input int rounds);
        int st, c; logic [31:0] r, e; logic [23:0] d; logic [4:0] a;
        for (int k = 0; k < rounds; k++) begin
            repeat ($urandom_range(1, 6)) bus_write(5'($urandom_range(0, N - 1)), $urandom, st);
            bus_write(5'($urandom_range(N, 29)), $urandom, st);
            bus_write(5'd31, 32'd1, st);
            idle(2);
            vblank();
            wait_irq(c);
            vectors++; if (c != N) begin errors++; $display("FAIL rand_copy_len round=%0d got=%0d exp=%0d", k, c, N); end
            bus_write(5'd30, $urandom, st);
            vectors++; if (frame_irq !== irq_m) begin errors++; $display("FAIL rand_ack round=%0d got=%b exp=%b", k, frame_irq, irq_m); end
            for (int s = 0; s < N; s++) begin
                get_desc(5'(s), d);
                vectors++; if (d !== active_m[s]) begin errors++; $display("FAIL rand_desc round=%0d slot=%0d got=%h exp=%h", k, s, d, active_m[s]); end
            end
            get_desc(5'($urandom_range(N, 31)), d);
            vectors++; if (d !== 24'd0) begin errors++; $display("FAIL rand_oob_slot round=%0d got=%h exp=0", k, d); end
            bus_read(5'($urandom_range(N, 29)), r);
            vectors++; if (r !== 32'd0) begin errors++; $display("FAIL rand_unmapped_read round=%0d got=%h exp=0", k, r); end
            a = 5'($urandom_range(0, N - 1));
            bus_read(a, r);
`ifdef SAT_READBACK_EN
            e = {8'b0, shadow_m[a]};
`else
            e = 32'd0;
`endif
            vectors++; if (r !== e) begin errors++; $display("FAIL rand_readback round=%0d addr=%0d got=%h exp=%h", k, a, r, e); end
        end
    endtask

    task automatic test_stall();
        int st, c; logic [31:0] v; logic [23:0] d;
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        idle(3);
        v = $urandom;
        bus_write(5'd5, v, st);
        vectors++; if (st != N - 3) begin errors++; $display("FAIL stall_cycles got=%0d exp=%0d", st, N - 3); end
        bus_write(5'd30, 32'd0, st);
        get_desc(5'd5, d);
        vectors++; if (d !== active_m[5]) begin errors++; $display("FAIL stall_not_yet_active got=%h exp=%h", d, active_m[5]); end
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        wait_irq(c);
        get_desc(5'd5, d);
        vectors++; if (d !== v[23:0]) begin errors++; $display("FAIL stall_after_commit got=%h exp=%h", d, v[23:0]); end
    endtask

    task automatic test_commit_during_copy();
        int st, c; logic [31:0] r, v; logic [23:0] d;
        bus_write(5'd30, 32'd0, st);
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        idle(3);
        bus_write(5'd31, 32'd1, st);
        vectors++; if (st != 0) begin errors++; $display("FAIL ctrl_write_stalled got=%0d exp=0", st); end
        wait_irq(c);
        vectors++; if (c != N - 4) begin errors++; $display("FAIL recommit_copy_len got=%0d exp=%0d", c, N - 4); end
        bus_read(5'd31, r);
        vectors++; if (r !== 32'd3) begin errors++; $display("FAIL recommit_status got=%h exp=3", r); end
        v = $urandom;
        bus_write(5'd11, v, st);
        bus_write(5'd30, 32'd0, st);
        vblank();
        wait_irq(c);
        vectors++; if (c != N) begin errors++; $display("FAIL second_copy_len got=%0d exp=%0d", c, N); end
        get_desc(5'd11, d);
        vectors++; if (d !== v[23:0]) begin errors++; $display("FAIL second_copy_desc got=%h exp=%h", d, v[23:0]); end
        bus_read(5'd31, r);
        vectors++; if (r !== 32'd2) begin errors++; $display("FAIL second_copy_status got=%h exp=2", r); end
    endtask

    task automatic test_irq_ack();
        int st;
        bus_write(5'd30, 32'd0, st);
        vectors++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL ack_pre got=%b exp=0", frame_irq); end
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        idle(N - 1);
        bus_write(5'd30, 32'd0, st);
        irq_m = 1;
        vectors++; if (frame_irq !== 1'b1) begin errors++; $display("FAIL ack_on_exit got=%b exp=1", frame_irq); end
        bus_write(5'd30, 32'd0, st);
        vectors++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL ack_after_exit got=%b exp=0", frame_irq); end
    endtask

    task automatic test_reset_during_copy();
        int st, c; logic [31:0] r; logic [23:0] d;
        bus_write(5'd9, $urandom | 32'h0080_0000, st);
        bus_write(5'd31, 32'd1, st);
        idle(2);
        vblank();
        wait_irq(c);
        bus_write(5'd30, 32'd0, st);
        bus_write(5'd9, $urandom | 32'h0080_0000, st);
        bus_write(5'd31, 32'd1, st);
        idle(2);
        rd_slot = 5'd9;
        vblank();
        idle(10);
        reset_n = 0;
        #1;
        vectors++; if (rd_desc !== 24'd0) begin errors++; $display("FAIL async_rst_desc got=%h exp=0", rd_desc); end
        vectors++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq got=%b exp=0", frame_irq); end
        @(negedge clk);
        reset_n = 1;
        model_clear();
        for (int s = 0; s < N; s++) begin
            get_desc(5'(s), d);
            vectors++; if (d !== 24'd0) begin errors++; $display("FAIL rstcopy_desc slot=%0d got=%h exp=0", s, d); end
        end
        bus_read(5'd31, r);
        vectors++; if (r !== 32'd0) begin errors++; $display("FAIL rstcopy_status got=%h exp=0", r); end
        bus_read(5'd25, r);
        vectors++; if (r !== 32'd0) begin errors++; $display("FAIL rstcopy_read25 got=%h exp=0", r); end
        vblank();
        idle(N + 5);
        vectors++; if (frame_irq !== 1'b0) begin errors++; $display("FAIL rstcopy_idle_irq got=%b exp=0", frame_irq); end
        get_desc(5'd9, d);
        vectors++; if (d !== 24'd0) begin errors++; $display("FAIL rstcopy_idle_desc got=%h exp=0", d); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_no_commit();
        test_random(6);
        test_stall();
        test_commit_during_copy();
        test_irq_ack();
        test_reset_during_copy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1);
    end
endmodule

// File: doc/sprite_attr_table.md
SPRITE_ATTR_TABLE -- requirements
Module: sprite_attr_table

Interface
REQ-001 Parameter NUM_SPRITES, 20, number of descriptor slots (max 30).
REQ-002 Parameter VBLANK_LINE, 480, VGA_VCOUNT value that marks vblank start.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 write  input  1  Avalon write strobe.
REQ-007 read  input  1  Avalon read strobe.
REQ-008 address  input  5  word address.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, registered.
REQ-011 waitrequest  output  1  Avalon stall.
REQ-012 VGA_HCOUNT  input  10  current pixel column.
REQ-013 VGA_VCOUNT  input  10  current line.
REQ-014 rd_slot  input  5  display-side slot index.
REQ-015 rd_desc  output  24  active descriptor {id[23:19], x[18:10], y[9:0]}.
REQ-016 frame_irq  output  1  commit-complete interrupt, level.

Function
REQ-017 The block SHALL hold a shadow table (CPU-written) and an active table (display-read), NUM_SPRITES x 24 bits each.
REQ-018 Map: addr 0..NUM_SPRITES-1 = shadow descriptor (writedata[23:0]); 30 = IRQ ack (write, any data); 31 = control/status; other addresses: writes ignored, reads 0.
REQ-019 Write to 31 with writedata[0]=1 SHALL set commit_pending; writedata[0]=0 has no effect.
REQ-020 Status read of 31 SHALL return {30'b0, frame_irq, commit_pending}.
REQ-021 FSM states IDLE, ARMED, COPY; IDLE->ARMED when commit_pending set; ARMED->COPY on vblank-start; COPY->IDLE after last slot.
REQ-022 vblank-start SHALL be the single cycle where VGA_VCOUNT==VBLANK_LINE and VGA_HCOUNT==0 and the previous cycle was not.
REQ-023 COPY SHALL copy one slot per cycle, slot 0 first, taking exactly NUM_SPRITES cycles.
REQ-024 On the cycle COPY exits, commit_pending SHALL clear and frame_irq SHALL set.
REQ-025 Commit write during ARMED SHALL have no effect; during COPY it SHALL set a new pending commit executed at the next vblank-start.
REQ-026 waitrequest SHALL be high only while FSM is COPY and chipselect&write targets a shadow address; all other accesses complete with waitrequest low.
REQ-027 readdata SHALL be valid the cycle after read&chipselect (latency 1).
REQ-028 rd_desc SHALL equal active[rd_slot] one cycle after rd_slot is presented; rd_slot>=NUM_SPRITES yields 0.
REQ-029 Write to 30 SHALL clear frame_irq; if the same cycle also ends COPY, frame_irq SHALL be set (set wins).
REQ-030 id field 0 denotes disabled slot; block does not interpret descriptor contents.

Reset
REQ-031 reset_n low SHALL asynchronously clear shadow and active tables, commit_pending, frame_irq, readdata, rd_desc, waitrequest, and force FSM to IDLE.
REQ-032 Reset during COPY SHALL abandon the copy; no partial table survives.

Configuration
REQ-033 With SAT_READBACK_EN defined, reads of addr 0..NUM_SPRITES-1 SHALL return {8'b0, shadow[addr]}.
REQ-034 Without SAT_READBACK_EN, those reads SHALL return 0 and no shadow read mux is built; status register unaffected.

Structure
REQ-035 Package sprite_pkg SHALL hold NUM_SPRITES default, VBLANK_LINE default, descriptor struct (id, x, y), field widths, register addresses 30/31, FSM state enum.
REQ-036 No sub-module; tables and FSM in sprite_attr_table.

Verification
REQ-037 Reset, write addr 3 = 0x0A1234, commit, drive VCOUNT=480 HCOUNT=0 -> after 20 cycles rd_slot=3 gives 0x0A1234, frame_irq=1, status=0b10.
REQ-038 Shadow write before commit, no commit -> rd_desc for that slot stays 0 across vblank.
REQ-039 Shadow write during COPY -> waitrequest=1 until COPY exits, then write completes; value appears only after next commit+vblank.
REQ-040 Commit during COPY -> status bit0 reads 1 after COPY exits; second copy at next vblank-start.
REQ-041 IRQ ack on COPY-exit cycle -> frame_irq remains 1; ack next cycle -> 0.
REQ-042 reset_n pulsed at COPY cycle 10 -> all rd_desc 0, status 0, FSM IDLE; read addr 25 -> 0.
